// File: rtl/gs_row_sequencer.sv
//------------------------------------------------------------------------------
// gs_row_sequencer : sweeps eight stored rows through an external Gauss-Seidel
//                    Core, writing each result back before the next row issues.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gs_row_sequencer #(
    parameter int N        = 8,
    parameter int WAIT_MAX = 1024
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load_valid,
    input  logic [2:0]    i_load_row,
    input  logic [55:0]   i_load_a,
    input  logic [7:0]    i_load_b,
    input  logic [31:0]   i_load_a_down,
    input  logic          i_start,
    input  logic [7:0]    i_iter,
    output logic          o_core_rst,
    output logic          o_core_valid,
    output logic [55:0]   o_core_a,
    output logic [7:0]    o_core_b,
    output logic [31:0]   o_core_a_down,
    output logic [223:0]  o_core_x,
    input  logic          i_core_valid,
    input  logic [31:0]   i_core_x_next,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [255:0]  o_x
);

    localparam int c_TIMER_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [55:0]            r_row_a     [N];
    logic [7:0]             r_row_b     [N];
    logic [31:0]            r_row_adown [N];
    logic [31:0]            r_x         [N];

    logic [2:0]             r_row;
    logic [7:0]             r_sweep;
    logic [7:0]             r_iter;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [31:0]            r_result;
    logic                   r_error;
    logic [55:0]            r_core_a;
    logic [7:0]             r_core_b;
    logic [31:0]            r_core_adown;
    logic [223:0]           r_core_x;

    logic [223:0]           w_pack;
    logic                   w_last_row;
    logic                   w_last_sweep;
    logic                   w_timer_last;

    assign w_last_row   = (r_row == 3'(N - 1));
    assign w_last_sweep = ((r_sweep + 8'd1) == r_iter);
    assign w_timer_last = (r_timer == c_TIMER_W'(WAIT_MAX - 1));

    // Neighbour vector skips the current row, keeping ascending order.
    for (genvar j = 0; j < N - 1; j++) begin : g_pack
        assign w_pack[32*j +: 32] = (3'(j) < r_row) ? r_x[j] : r_x[j+1];
    end

    for (genvar j = 0; j < N; j++) begin : g_ox
        assign o_x[32*j +: 32] = r_x[j];
    end

    // Row storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_load_valid && (r_state == S_IDLE)) begin
            r_row_a[i_load_row]     <= i_load_a;
            r_row_b[i_load_row]     <= i_load_b;
            r_row_adown[i_load_row] <= i_load_a_down;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_core_rst   = 1'b0;
        o_core_valid = 1'b0;
        o_done       = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = (i_iter == 8'd0) ? S_DONE : S_CLR;
                end
            end
            S_CLR: begin
                o_core_rst = 1'b1;
                w_next     = S_ISSUE;
            end
            S_ISSUE: begin
                o_core_valid = 1'b1;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_valid) begin
                    w_next = S_WRITE;
                end else if (w_timer_last) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE: begin
                w_next = (w_last_row && w_last_sweep) ? S_DONE : S_CLR;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_x[k] <= 32'd0;
            end
            r_row        <= 3'd0;
            r_sweep      <= 8'd0;
            r_iter       <= 8'd0;
            r_timer      <= '0;
            r_result     <= 32'd0;
            r_error      <= 1'b0;
            r_core_a     <= 56'd0;
            r_core_b     <= 8'd0;
            r_core_adown <= 32'd0;
            r_core_x     <= 224'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        for (int k = 0; k < N; k++) begin
                            r_x[k] <= 32'd0;
                        end
                        r_row   <= 3'd0;
                        r_sweep <= 8'd0;
                        r_iter  <= i_iter;
                        r_error <= 1'b0;
                    end
                end
                // Snapshot here so the Core sees stable data through WAIT.
                S_CLR: begin
                    r_core_a     <= r_row_a[r_row];
                    r_core_b     <= r_row_b[r_row];
                    r_core_adown <= r_row_adown[r_row];
                    r_core_x     <= w_pack;
                end
                S_ISSUE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (i_core_valid) begin
                        r_result <= i_core_x_next;
                    end else if (w_timer_last) begin
                        r_error <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_x[r_row] <= r_result;
                    if (w_last_row) begin
                        r_row   <= 3'd0;
                        r_sweep <= r_sweep + 8'd1;
                    end else begin
                        r_row <= r_row + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_core_a      = r_core_a;
    assign o_core_b      = r_core_b;
    assign o_core_a_down = r_core_adown;
    assign o_core_x      = r_core_x;
    assign o_error       = r_error;

endmodule

`default_nettype wire
